ddr5_bank_responder: RTL

// - DRAM-side responder for the scheduler's DDR5 command stream: a single-rank bank-state and timing model.
// - Tracks open/closed state and timing counters per bank (bank groups x banks).
// - Drives read bursts, checks write bursts, and flags every illegal or early command.
// - Sits behind the scheduler in the testbench/sim top; used as a self-checking DUT partner.

---
 rtl/ddr5_bank_responder.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr5_bank_responder.sv
// ddr5_bank_responder: DRAM-side bank-state and timing model for one DDR5 rank.
// It tracks open/closed state, the latched row and timing counters for every
// bank (bank groups x banks). It returns read bursts, checks the presence of
// write beats, and reports illegal or early commands as a registered
// one-cycle pulse carrying a code.
//
// Ports:
//   clock, reset_n           sole clock (posedge); asynchronous active-low reset
//   cmd_valid, cmd           command strobe and opcode:
//                            0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6/7 NOP
//   cmd_bg, cmd_ba           target bank group / bank
//   cmd_row, cmd_col         row (ACT) / column (RD, WR)
//   wr_data_valid, wr_data   write beat strobe; the data content is ignored
//   rd_data_valid, rd_data   read beat, zero-extended {bg, ba, row, col, beat}
//   bank_open                per-bank open flag, indexed by {bg, ba}
//   viol, viol_code          violation pulse and its code (lowest code wins)
//   viol_count               only with DDR5_VIOL_COUNT_EN defined: saturating
//                            count of viol pulses
//
// Timing counters hold N-1 after a command with constraint N. They decrement
// to zero, so a follow-on command is legal in the first cycle its counter
// reads zero, which is exactly T+N.

module ddr5_bank_state #(
  parameter int ROW_BITS = 16,
  parameter int T_RCD    = 39,
  parameter int T_RAS    = 76,
  parameter int T_RP     = 39,
  parameter int T_RTP    = 18,
  parameter int T_WREC   = 118   // WR to PRE: T_CWD + T_BURST + T_WR
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                act,
  input  logic                pre,
  input  logic                rd,
  input  logic                wr,
  input  logic [ROW_BITS-1:0] row_in,
  output logic                is_open,
  output logic [ROW_BITS-1:0] row,
  output logic                rcd_ok,
  output logic                ras_ok,
  output logic                rp_ok,
  output logic                rtp_ok,
  output logic                wr_ok
);
  localparam logic [8:0] L_RCD = 9'(T_RCD - 1);
  localparam logic [8:0] L_RAS = 9'(T_RAS - 1);
  localparam logic [8:0] L_RP  = 9'(T_RP - 1);
  localparam logic [8:0] L_RTP = 9'(T_RTP - 1);
  localparam logic [8:0] L_WR  = 9'(T_WREC - 1);

  logic [8:0] rcd_cnt, ras_cnt, rp_cnt, rtp_cnt, wr_cnt;

  function automatic logic [8:0] dec(input logic [8:0] c);
    return (c == 9'd0) ? 9'd0 : c - 9'd1;
  endfunction

  assign rcd_ok = (rcd_cnt == 9'd0);
  assign ras_ok = (ras_cnt == 9'd0);
  assign rp_ok  = (rp_cnt  == 9'd0);
  assign rtp_ok = (rtp_cnt == 9'd0);
  assign wr_ok  = (wr_cnt  == 9'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_open <= 1'b0;
      row     <= '0;
      rcd_cnt <= '0;
      ras_cnt <= '0;
      rp_cnt  <= '0;
      rtp_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      rcd_cnt <= act ? L_RCD : dec(rcd_cnt);
      ras_cnt <= act ? L_RAS : dec(ras_cnt);
      rp_cnt  <= pre ? L_RP  : dec(rp_cnt);
      rtp_cnt <= rd  ? L_RTP : dec(rtp_cnt);
      wr_cnt  <= wr  ? L_WR  : dec(wr_cnt);
      if (act) begin
        is_open <= 1'b1;
        row     <= row_in;
      end else if (pre) begin
        is_open <= 1'b0;
      end
    end
  end
endmodule

module ddr5_bank_responder #(
  parameter int BG_BITS  = 3,
  parameter int BA_BITS  = 2,
  parameter int ROW_BITS = 16,
  parameter int COL_BITS = 10,
  parameter int DATA_W   = 64,
  parameter int T_RCD    = 39,
  parameter int T_RAS    = 76,
  parameter int T_RP     = 39,
  parameter int T_RTP    = 18,
  parameter int T_CL     = 40,
  parameter int T_CWD    = 38,
  parameter int T_BURST  = 8,
  parameter int T_WR     = 72,
  parameter int T_RFC    = 295
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              cmd_valid,
  input  logic [2:0]                        cmd,
  input  logic [BG_BITS-1:0]                cmd_bg,
  input  logic [BA_BITS-1:0]                cmd_ba,
  input  logic [ROW_BITS-1:0]               cmd_row,
  input  logic [COL_BITS-1:0]               cmd_col,
  input  logic                              wr_data_valid,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic                              rd_data_valid,
  output logic [DATA_W-1:0]                 rd_data,
  output logic [(1<<(BG_BITS+BA_BITS))-1:0] bank_open,
  output logic                              viol,
  output logic [3:0]                        viol_code
`ifdef DDR5_VIOL_COUNT_EN
  ,
  output logic [15:0]                       viol_count
`endif
);
  localparam int NB = 1 << (BG_BITS + BA_BITS);

  localparam logic [8:0] L_RFC    = 9'(T_RFC - 1);
  localparam logic [8:0] L_RD_BUS = 9'(T_CL + T_BURST - 1);
  localparam logic [8:0] L_WR_BUS = 9'(T_CWD + T_BURST - 1);
  // Burst position counts cycles since the RD/WR edge (1 on the next edge).
  // Read beats are launched one edge early because rd_data is registered.
  localparam logic [8:0] RD_FIRST = 9'(T_CL - 1);
  localparam logic [8:0] RD_LAST  = 9'(T_CL + T_BURST - 2);
  localparam logic [8:0] WR_FIRST = 9'(T_CWD);
  localparam logic [8:0] WR_LAST  = 9'(T_CWD + T_BURST - 1);

  function automatic logic [8:0] dec(input logic [8:0] c);
    return (c == 9'd0) ? 9'd0 : c - 9'd1;
  endfunction

  logic [BG_BITS+BA_BITS-1:0] sel;
  logic [NB-1:0]              sel_oh;
  logic is_act, is_rd, is_wr, is_pre, is_ref;
  logic act_go, rd_go, wr_go, pre_go, ref_go, cmd_bad;

  logic [NB-1:0]               open_v, rcd_ok_v, ras_ok_v, rp_ok_v, rtp_ok_v, wr_ok_v;
  logic [NB-1:0][ROW_BITS-1:0] row_v;
  logic                        s_open;
  logic [ROW_BITS-1:0]         s_row;

  logic [8:0] rfc_cnt, bus_cnt, bus_pos, bus_last;
  logic       bus_act, bus_is_rd, rd_beat, wr_exp, beat_err;
  logic [BG_BITS-1:0]  rd_bg;
  logic [BA_BITS-1:0]  rd_ba;
  logic [ROW_BITS-1:0] rd_row;
  logic [COL_BITS-1:0] rd_col;
  logic [3:0]          beat;

  logic [11:1] flags;
  logic [3:0]  code_nxt;
  logic        unused_wr_data;

  assign unused_wr_data = ^wr_data;

  assign sel    = {cmd_bg, cmd_ba};
  assign sel_oh = NB'(1) << sel;
  assign is_act = cmd_valid && (cmd == 3'b001);
  assign is_rd  = cmd_valid && (cmd == 3'b010);
  assign is_wr  = cmd_valid && (cmd == 3'b011);
  assign is_pre = cmd_valid && (cmd == 3'b100);
  assign is_ref = cmd_valid && (cmd == 3'b101);

  for (genvar i = 0; i < NB; i++) begin : g_bank
    ddr5_bank_state #(
      .ROW_BITS(ROW_BITS), .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP),
      .T_RTP(T_RTP), .T_WREC(T_CWD + T_BURST + T_WR)
    ) u_bank (
      .clock   (clock),
      .reset_n (reset_n),
      .act     (act_go & sel_oh[i]),
      .pre     (pre_go & sel_oh[i]),
      .rd      (rd_go  & sel_oh[i]),
      .wr      (wr_go  & sel_oh[i]),
      .row_in  (cmd_row),
      .is_open (open_v[i]),
      .row     (row_v[i]),
      .rcd_ok  (rcd_ok_v[i]),
      .ras_ok  (ras_ok_v[i]),
      .rp_ok   (rp_ok_v[i]),
      .rtp_ok  (rtp_ok_v[i]),
      .wr_ok   (wr_ok_v[i])
    );
  end

  assign bank_open = open_v;
  assign s_open    = open_v[sel];
  assign s_row     = row_v[sel];

  // Data-bus window of the single outstanding burst.
  assign bus_last = bus_is_rd ? RD_LAST : WR_LAST;
  assign rd_beat  = bus_act &&  bus_is_rd && (bus_pos >= RD_FIRST) && (bus_pos <= RD_LAST);
  assign wr_exp   = bus_act && !bus_is_rd && (bus_pos >= WR_FIRST) && (bus_pos <= WR_LAST);
  assign beat_err = (wr_data_valid != wr_exp);
  assign beat     = 4'(bus_pos - RD_FIRST);

  always_comb begin
    flags     = '0;
    flags[10] = beat_err;
    if (is_act) begin
      flags[2] = s_open;
      flags[5] = !rp_ok_v[sel];
      flags[8] = (rfc_cnt != 9'd0);
    end
    if (is_rd || is_wr) begin
      flags[1] = !s_open;
      flags[3] = !rcd_ok_v[sel];
      flags[8] = (rfc_cnt != 9'd0);
      flags[9] = (bus_cnt != 9'd0);
    end
    // PRE to a closed bank is a plain NOP.
    if (is_pre && s_open) begin
      flags[4] = !ras_ok_v[sel];
      flags[6] = !rtp_ok_v[sel];
      flags[7] = !wr_ok_v[sel];
      flags[8] = (rfc_cnt != 9'd0);
    end
    if (is_ref) begin
      flags[8]  = (rfc_cnt != 9'd0);
      flags[11] = |open_v;
    end
  end

  always_comb begin
    code_nxt = '0;
    for (int i = 11; i >= 1; i--)
      if (flags[i]) code_nxt = 4'(i);
  end

  // A beat error alone does not drop the command issued in the same cycle.
  assign cmd_bad = (|flags[9:1]) || flags[11];
  assign act_go  = is_act && !cmd_bad;
  assign rd_go   = is_rd  && !cmd_bad;
  assign wr_go   = is_wr  && !cmd_bad;
  assign pre_go  = is_pre && s_open && !cmd_bad;
  assign ref_go  = is_ref && !cmd_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rfc_cnt       <= '0;
      bus_cnt       <= '0;
      bus_pos       <= '0;
      bus_act       <= 1'b0;
      bus_is_rd     <= 1'b0;
      rd_bg         <= '0;
      rd_ba         <= '0;
      rd_row        <= '0;
      rd_col        <= '0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
      viol          <= 1'b0;
      viol_code     <= '0;
    end else begin
      rfc_cnt       <= ref_go ? L_RFC : dec(rfc_cnt);
      viol          <= |flags;
      viol_code     <= code_nxt;
      rd_data_valid <= rd_beat;
      rd_data       <= rd_beat ? DATA_W'({rd_bg, rd_ba, rd_row, rd_col, beat}) : '0;
      if (rd_go || wr_go) begin
        bus_cnt   <= rd_go ? L_RD_BUS : L_WR_BUS;
        bus_act   <= 1'b1;
        bus_is_rd <= rd_go;
        bus_pos   <= 9'd1;
        rd_bg     <= cmd_bg;
        rd_ba     <= cmd_ba;
        rd_row    <= s_row;
        rd_col    <= cmd_col;
      end else begin
        bus_cnt <= dec(bus_cnt);
        if (bus_act) begin
          bus_pos <= bus_pos + 9'd1;
          if (bus_pos == bus_last) bus_act <= 1'b0;
        end
      end
    end
  end

`ifdef DDR5_VIOL_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      viol_count <= '0;
    else if ((|flags) && (viol_count != 16'hFFFF))
      viol_count <= viol_count + 16'd1;
  end
`endif
endmodule
